// File: rtl/arm_defs.sv
// Shared ARM condition-code encodings and flag bit positions.
// Flag vectors are ordered {Z,C,N,V}.
package arm_defs;

  localparam int COND_W = 4;

  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [COND_W-1:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_e;

  // AL and NV ignore the flags, so they never wait on a pending flag writer.
  function automatic logic is_uncond(input logic [COND_W-1:0] cond);
    return (cond == COND_AL) || (cond == COND_NV);
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition evaluator over a {Z,C,N,V} flag vector.
module cond_eval
  import arm_defs::*;
(
  input  logic [COND_W-1:0] cond,
  input  logic [3:0]        flags,
  output logic              pass
);

  logic z, c, n, v;

  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign n = flags[FLAG_N];
  assign v = flags[FLAG_V];

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_hazard_ctrl.sv
// Flag hazard scoreboard for a conditional-execution pipeline: tracks flag
// writers in EXE/MEM/WB, stalls dependent ID instructions, bypasses from WB.
module flag_hazard_ctrl
  import arm_defs::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [COND_W-1:0] id_cond,
  input  logic              id_s,
  input  logic              freeze,
  input  logic              flush,
  input  logic              wb_flag_we,
  input  logic [3:0]        wb_flags,
  output logic [3:0]        status_register,
  output logic              cond_pass,
  output logic              hazard_stall,
  output logic [15:0]       stall_count
);

  // pend[0]=EXE, pend[1]=MEM, pend[2]=WB
  logic [2:0]  pend;
  logic [3:0]  status_q;
  logic [15:0] stall_cnt;

  logic        needs_flags;
  logic        bypass;
  logic [3:0]  eval_flags;
  logic        cond_true;
  logic        issue;

  assign needs_flags = ~is_uncond(id_cond);

  // Only the WB writer is in flight: its flags are on the bus this cycle.
  assign bypass     = (pend == 3'b100) & wb_flag_we;
  assign eval_flags = bypass ? wb_flags : status_q;

  cond_eval u_cond_eval (
    .cond  (id_cond),
    .flags (eval_flags),
    .pass  (cond_true)
  );

  assign hazard_stall = rst_n & id_valid & ~flush & needs_flags & (pend[0] | pend[1]);
  assign cond_pass    = rst_n & id_valid & ~hazard_stall & ~flush & cond_true;
  assign issue        = cond_pass & id_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= 3'b000;
    end else if (!freeze) begin
      if (flush)
        pend <= {pend[1], 2'b00};
      else if (hazard_stall)
        pend <= {pend[1:0], 1'b0};
      else
        pend <= {pend[1:0], issue};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      status_q <= 4'b0000;
    else if (wb_flag_we)
      status_q <= wb_flags;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= 16'd0;
    else if (hazard_stall && !freeze && !(&stall_cnt))
      stall_cnt <= stall_cnt + 16'd1;
  end

  assign status_register = status_q;
  assign stall_count     = stall_cnt;

endmodule

// File: tb/tb_flag_hazard_ctrl.sv
// Directed bench for flag_hazard_ctrl with hand-computed expectations.
module tb_flag_hazard_ctrl;
  import arm_defs::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [3:0]  id_cond;
  logic        id_s;
  logic        freeze;
  logic        flush;
  logic        wb_flag_we;
  logic [3:0]  wb_flags;
  logic [3:0]  status_register;
  logic        cond_pass;
  logic        hazard_stall;
  logic [15:0] stall_count;

  int checks = 0;
  int errs   = 0;

  flag_hazard_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_valid        (id_valid),
    .id_cond         (id_cond),
    .id_s            (id_s),
    .freeze          (freeze),
    .flush           (flush),
    .wb_flag_we      (wb_flag_we),
    .wb_flags        (wb_flags),
    .status_register (status_register),
    .cond_pass       (cond_pass),
    .hazard_stall    (hazard_stall),
    .stall_count     (stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] exp_tab;

  initial begin
    rst_n = 1'b0; id_valid = 1'b1; id_cond = COND_AL; id_s = 1'b0;
    freeze = 1'b0; flush = 1'b0; wb_flag_we = 1'b0; wb_flags = 4'b0000;
    #2;
    chk_eq("rst_stall", hazard_stall, 0);
    chk_eq("rst_pass", cond_pass, 0);
    chk_eq("rst_status", status_register, 0);
    chk_eq("rst_count", stall_count, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // EQ with cleared flags
    id_cond = COND_EQ; #1;
    chk_eq("eq0_pass", cond_pass, 0);
    chk_eq("eq0_stall", hazard_stall, 0);

    // CMP then BEQ: two stall cycles, then bypass from WB
    id_cond = COND_AL; id_s = 1'b1; #1;
    chk_eq("cmp_pass", cond_pass, 1);
    tick();
    id_cond = COND_EQ; id_s = 1'b0; #1;
    chk_eq("beq_stall1", hazard_stall, 1);
    chk_eq("beq_stall1_pass", cond_pass, 0);
    tick();
    chk_eq("beq_stall2", hazard_stall, 1);
    tick();
    wb_flag_we = 1'b1; wb_flags = 4'b1000; #1;
    chk_eq("beq_bypass_stall", hazard_stall, 0);
    chk_eq("beq_bypass_pass", cond_pass, 1);
    chk_eq("beq_count", stall_count, 2);
    tick();
    wb_flag_we = 1'b0; id_valid = 1'b0;
    chk_eq("beq_status", status_register, 4'b1000);

    // S instruction issued, then flushed in EXE
    id_valid = 1'b1; id_cond = COND_AL; id_s = 1'b1;
    tick();
    flush = 1'b1; id_cond = COND_EQ; #1;
    chk_eq("flush_stall", hazard_stall, 0);
    chk_eq("flush_pass", cond_pass, 0);
    tick();
    flush = 1'b0; id_s = 1'b0; #1;
    chk_eq("post_flush_stall", hazard_stall, 0);
    chk_eq("post_flush_pass", cond_pass, 1);
    chk_eq("post_flush_count", stall_count, 2);
    tick();

    // writer in MEM held by freeze for 3 cycles
    id_cond = COND_AL; id_s = 1'b1;
    tick();
    id_valid = 1'b0; id_s = 1'b0;
    tick();
    id_valid = 1'b1; id_cond = COND_EQ; freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        wb_flag_we = 1'b1; wb_flags = 4'b0100;
      end
      #1;
      chk_eq("frz_stall", hazard_stall, 1);
      chk_eq("frz_count", stall_count, 2);
      tick();
    end
    wb_flag_we = 1'b0; freeze = 1'b0;
    chk_eq("frz_status_write", status_register, 4'b0100);
    #1;
    chk_eq("unfrz_stall", hazard_stall, 1);
    tick();
    chk_eq("unfrz_count", stall_count, 3);
    id_cond = COND_CS; wb_flag_we = 1'b1; wb_flags = 4'b0000; #1;
    chk_eq("bypass_cs_stall", hazard_stall, 0);
    chk_eq("bypass_cs_pass", cond_pass, 0);
    tick();
    wb_flag_we = 1'b0;

    // full condition table against two flag patterns
    for (int p = 0; p < 2; p++) begin
      id_valid = 1'b0; wb_flag_we = 1'b1;
      wb_flags = (p == 0) ? 4'b0110 : 4'b1001;
      exp_tab  = (p == 0) ? 16'h6996 : 16'h6A69;
      tick();
      wb_flag_we = 1'b0; id_valid = 1'b1; id_s = 1'b0;
      for (int c = 0; c < 16; c++) begin
        id_cond = 4'(c); #1;
        chk_eq($sformatf("cond_tab_p%0d_c%0d", p, c), cond_pass, exp_tab[c]);
        tick();
      end
    end

    // AL/NV with writers in EXE and MEM
    id_cond = COND_AL; id_s = 1'b1;
    tick();
    tick();
    id_s = 1'b0; id_cond = COND_NV; #1;
    chk_eq("nv_pend_pass", cond_pass, 0);
    chk_eq("nv_pend_stall", hazard_stall, 0);
    id_cond = COND_AL; #1;
    chk_eq("al_pend_pass", cond_pass, 1);
    chk_eq("al_pend_stall", hazard_stall, 0);
    id_cond = COND_NE; #1;
    chk_eq("ne_pend_stall", hazard_stall, 1);
    id_valid = 1'b0;
    tick(); tick(); tick();

    // saturation and asynchronous reset mid-stall
    wb_flag_we = 1'b1; wb_flags = 4'b1111;
    tick();
    wb_flag_we = 1'b0;
    force dut.stall_cnt = 16'hFFFE;
    #1;
    release dut.stall_cnt;
    #1;
    id_valid = 1'b1; id_cond = COND_AL; id_s = 1'b1;
    tick();
    id_cond = COND_EQ; id_s = 1'b0; #1;
    chk_eq("sat_stall1", hazard_stall, 1);
    tick();
    chk_eq("sat_count1", stall_count, 16'hFFFF);
    chk_eq("sat_stall2", hazard_stall, 1);
    tick();
    chk_eq("sat_count2", stall_count, 16'hFFFF);
    id_cond = COND_AL; id_s = 1'b1; #1;
    chk_eq("sat_issue", cond_pass, 1);
    tick();
    id_cond = COND_EQ; id_s = 1'b0; #1;
    chk_eq("pre_rst_stall", hazard_stall, 1);
    rst_n = 1'b0; #1;
    chk_eq("mid_rst_stall", hazard_stall, 0);
    chk_eq("mid_rst_pass", cond_pass, 0);
    chk_eq("mid_rst_status", status_register, 0);
    chk_eq("mid_rst_count", stall_count, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    id_cond = COND_NE; #1;
    chk_eq("post_rst_stall", hazard_stall, 0);
    chk_eq("post_rst_pass", cond_pass, 1);
    chk_eq("post_rst_count", stall_count, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
